led_blink_arbiter: RTL and testbench
====================================

LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 SHALL have parameter: CLK_DIV, 10000000, clock cycles per blink phase (ON, OFF, GAP); legal range >= 2.
REQ-002 SHALL have port: i_Clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port: i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_Req  input  4  per-requester level request; bit k = requester k.
REQ-005 SHALL have port: i_Blinks  input  16  blink count per requester; bits [4k+3:4k] = requester k, unsigned 0..15.
REQ-006 SHALL have port: o_Grant  output  4  one-hot owner of the LED; all-zero when no owner.
REQ-007 SHALL have port: o_Done  output  4  one-cycle completion pulse, bit k = requester k.
REQ-008 SHALL have port: o_Busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port: o_LED  output  1  shared LED drive; all outputs registered.

Function
REQ-010 SHALL implement FSM states IDLE, ON, OFF, GAP.
REQ-011 SHALL run a prescaler of width clog2(CLK_DIV) that clears on every state entry; a tick occurs when it equals CLK_DIV-1, so each ON/OFF/GAP phase lasts exactly CLK_DIV cycles.
REQ-012 SHALL arbitrate in IDLE round-robin: search starts at the requester after the last granted one, wrapping 3->0.
REQ-013 SHALL, when in IDLE and any i_Req bit is high at edge t, assert o_Grant for the winner and latch its 4-bit blink count at edge t (one cycle grant latency).
REQ-014 SHALL, on grant with count >= 1, enter ON; o_LED high throughout ON, low in OFF, GAP and IDLE.
REQ-015 SHALL, on ON tick, enter OFF and decrement the latched count; on OFF tick, enter ON if count != 0, else GAP.
REQ-016 SHALL, for count n >= 1, produce exactly n LED pulses of CLK_DIV cycles separated by CLK_DIV low cycles.
REQ-017 SHALL, on grant with count 0, enter GAP directly with no LED pulse.
REQ-018 SHALL, on entry to GAP from normal completion, clear o_Grant and pulse o_Done for the owner in the same cycle.
REQ-019 SHALL, on GAP tick, return to IDLE; arbitration resumes from IDLE (new owner no sooner than 1 cycle after GAP ends).
REQ-020 SHALL, if the owner's i_Req falls while in ON or OFF, abort: next edge enters GAP with o_LED low, o_Grant cleared, and no o_Done pulse.
REQ-021 SHALL ignore i_Req/i_Blinks changes from non-owners and i_Blinks changes from the owner after grant.
REQ-022 SHALL update the round-robin pointer to the winner at each grant, including count-0 grants.

Reset
REQ-023 SHALL, while i_Rst_L is low, immediately force state IDLE, prescaler 0, count 0, pointer so requester 0 has highest priority, o_Grant=0, o_Done=0, o_Busy=0, o_LED=0.
REQ-024 SHALL, on reset assertion mid-operation, drop ownership with no o_Done pulse; first grant is possible at the first edge after release.

Configuration
REQ-025 SHALL honour macro LED_BLINK_ARBITER_HEARTBEAT_EN: when defined, in IDLE the prescaler free-runs and o_LED toggles on each tick (heartbeat); on grant o_LED is forced low before ON begins and the prescaler clears.
REQ-026 SHALL, when LED_BLINK_ARBITER_HEARTBEAT_EN is undefined, keep the prescaler at 0 and o_LED low in IDLE; all other behaviour is identical.

Verification (CLK_DIV=4)
REQ-027 SHALL cover: i_Req=0001, count0=3 -> o_Grant=0001 next cycle; o_LED pattern 4 high/4 low x3; o_Done=0001 pulse for 1 cycle; o_Busy low 4 cycles later.
REQ-028 SHALL cover: i_Req=1111 held, all counts 1 -> grants in order 0001,0010,0100,1000,0001, each separated by a 4-cycle GAP plus 1 IDLE cycle.
REQ-029 SHALL cover: count=0 grant -> no o_LED pulse; o_Done at the cycle after grant; GAP of 4 cycles.
REQ-030 SHALL cover: owner drops i_Req in 2nd ON phase of count 5 -> o_LED low next cycle; o_Grant cleared; no o_Done; next requester served after GAP.
REQ-031 SHALL cover: i_Rst_L low mid-OFF -> all outputs 0 without a clock edge; after release, i_Req=0110 -> grant 0010.
REQ-032 SHALL cover: with HEARTBEAT_EN defined and no requests -> o_LED toggles every 4 cycles; with the macro undefined -> o_LED constant 0.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: four requesters share one LED. A round-robin arbiter in
// IDLE picks an owner, which then gets its latched number of blinks
// (CLK_DIV cycles on, CLK_DIV cycles off), followed by a CLK_DIV-cycle GAP.
// Optional build macro LED_BLINK_ARBITER_HEARTBEAT_EN: when defined, the LED
// toggles once per CLK_DIV cycles while the arbiter is idle.
//
// state | meaning
// IDLE  | no owner; arbitrate on i_Req (heartbeat runs here if enabled)
// ON    | owner's blink, LED high for CLK_DIV cycles
// OFF   | LED low for CLK_DIV cycles between blinks
// GAP   | LED low for CLK_DIV cycles after completion, zero-count grant or abort
module led_blink_arbiter #(
   parameter int CLK_DIV = 10000000
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic [3:0]  i_Req,
   input  logic [15:0] i_Blinks,
   output logic [3:0]  o_Grant,
   output logic [3:0]  o_Done,
   output logic        o_Busy,
   output logic        o_LED
);

   localparam int            PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] TC = PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    count_q, count_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [3:0]    grant_q, grant_d;
   logic [3:0]    done_q, done_d;
   logic          zdone_q, zdone_d;
   logic          busy_q, busy_d;
   logic          led_q, led_d;

   logic          tick;
   logic          owner_req;
   logic          win_vld;
   logic [1:0]    win_idx;
   logic [1:0]    cand;

   assign tick      = (presc_q == TC);
   assign owner_req = |(i_Req & grant_q);

   // Round-robin search starting one past the last winner, wrapping 3 -> 0.
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr_q;
      cand    = ptr_q;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!win_vld && i_Req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Next-state, ownership, count and completion logic.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      done_d  = 4'b0000;
      zdone_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               ptr_d   = win_idx;
               grant_d = 4'b0001 << win_idx;
               count_d = i_Blinks[{win_idx, 2'b00} +: 4];
               if (count_d != 4'd0) begin
                  state_d = S_ON;
               end else begin
                  // Zero-count owner keeps the grant for one cycle, then
                  // completes from inside GAP.
                  state_d = S_GAP;
                  zdone_d = 1'b1;
               end
            end
         end
         S_ON: begin
            if (!owner_req) begin
               state_d = S_GAP;
               grant_d = 4'b0000;
            end else if (tick) begin
               state_d = S_OFF;
               count_d = count_q - 4'd1;
            end
         end
         S_OFF: begin
            if (!owner_req) begin
               state_d = S_GAP;
               grant_d = 4'b0000;
            end else if (tick) begin
               if (count_q != 4'd0) begin
                  state_d = S_ON;
               end else begin
                  state_d = S_GAP;
                  grant_d = 4'b0000;
                  done_d  = grant_q;
               end
            end
         end
         S_GAP: begin
            if (zdone_q) begin
               grant_d = 4'b0000;
               done_d  = grant_q;
            end
            if (tick) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   // Prescaler restarts on every state change; LED follows the next state.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      led_d  = 1'b0;
      if (state_d != state_q) begin
         presc_d = '0;
      end else if (state_q == S_IDLE) begin
`ifdef LED_BLINK_ARBITER_HEARTBEAT_EN
         presc_d = tick ? '0 : presc_q + 1'b1;
`else
         presc_d = '0;
`endif
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (state_d == S_ON) begin
         led_d = 1'b1;
      end else if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
`ifdef LED_BLINK_ARBITER_HEARTBEAT_EN
         led_d = tick ? ~led_q : led_q;
`else
         led_d = 1'b0;
`endif
      end
   end

   // State and registered outputs; pointer resets so requester 0 wins first.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         count_q <= 4'd0;
         ptr_q   <= 2'd3;
         grant_q <= 4'b0000;
         done_q  <= 4'b0000;
         zdone_q <= 1'b0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         zdone_q <= zdone_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
      end
   end

   assign o_Grant = grant_q;
   assign o_Done  = done_q;
   assign o_Busy  = busy_q;
   assign o_LED   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with CLK_DIV = 4.
module tb_led_blink_arbiter;

   logic        clk = 1'b0;
   logic        rst_l = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [15:0] blinks = 16'h0000;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic        led;

   int tests_run = 0;
   int tests_failed = 0;

   led_blink_arbiter #(.CLK_DIV(4)) dut (
      .i_Clk    (clk),
      .i_Rst_L  (rst_l),
      .i_Req    (req),
      .i_Blinks (blinks),
      .o_Grant  (grant),
      .o_Done   (done),
      .o_Busy   (busy),
      .o_LED    (led)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after an edge with reset released, so the
   // next edge is the first one at which a grant may happen.
   task automatic do_reset();
      req    = 4'b0000;
      blinks = 16'h0000;
      step();
      rst_l = 1'b0;
      step();
      rst_l = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_l = 1'b0;
      #2;
      tests_run++;
      if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant); end
      tests_run++;
      if (done !== 4'b0000) begin tests_failed++; $display("FAIL reset_done: got %b expected 0000", done); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests_run++;
      if (led !== 1'b0) begin tests_failed++; $display("FAIL reset_led: got %b expected 0", led); end
      step();
      rst_l = 1'b1;
   endtask

   task automatic test_single();
      logic exp_led;
      do_reset();
      blinks = 16'h0003;
      req    = 4'b0001;
      step();
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy); end
      for (int k = 1; k <= 24; k++) begin
         exp_led = (((k - 1) / 4) % 2) == 0;
         tests_run++;
         if (led !== exp_led) begin tests_failed++; $display("FAIL single_led c%0d: got %b expected %b", k, led, exp_led); end
         tests_run++;
         if (grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant c%0d: got %b expected 0001", k, grant); end
         tests_run++;
         if (done !== 4'b0000) begin tests_failed++; $display("FAIL single_done_early c%0d: got %b expected 0000", k, done); end
         step();
      end
      tests_run++;
      if (done !== 4'b0001) begin tests_failed++; $display("FAIL single_done: got %b expected 0001", done); end
      tests_run++;
      if (grant !== 4'b0000) begin tests_failed++; $display("FAIL single_grant_clr: got %b expected 0000", grant); end
      tests_run++;
      if (led !== 1'b0) begin tests_failed++; $display("FAIL single_led_gap: got %b expected 0", led); end
      req = 4'b0000;
      for (int k = 26; k <= 29; k++) begin
         step();
         tests_run++;
         if (done !== 4'b0000) begin tests_failed++; $display("FAIL single_done_len c%0d: got %b expected 0000", k, done); end
         tests_run++;
         if (busy !== (k < 29)) begin tests_failed++; $display("FAIL single_busy_gap c%0d: got %b expected %b", k, busy, (k < 29)); end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] one;
      logic [3:0] exp_g;
      logic [3:0] exp_d;
      int p;
      int g;
      one = 4'b0001;
      do_reset();
      blinks = 16'h1111;
      req    = 4'b1111;
      for (int c = 1; c <= 53; c++) begin
         step();
         p = (c - 1) % 13;
         g = ((c - 1) / 13) % 4;
         exp_g = (p < 8) ? (one << g) : 4'b0000;
         exp_d = (p == 8) ? (one << g) : 4'b0000;
         tests_run++;
         if (grant !== exp_g) begin tests_failed++; $display("FAIL rr_grant c%0d: got %b expected %b", c, grant, exp_g); end
         tests_run++;
         if (done !== exp_d) begin tests_failed++; $display("FAIL rr_done c%0d: got %b expected %b", c, done, exp_d); end
         tests_run++;
         if (busy !== (p != 12)) begin tests_failed++; $display("FAIL rr_busy c%0d: got %b expected %b", c, busy, (p != 12)); end
      end
   endtask

   task automatic test_zero_count();
      do_reset();
      blinks = 16'h0000;
      req    = 4'b0001;
      step();
      tests_run++;
      if (grant !== 4'b0001) begin tests_failed++; $display("FAIL zero_grant: got %b expected 0001", grant); end
      tests_run++;
      if (done !== 4'b0000) begin tests_failed++; $display("FAIL zero_done_early: got %b expected 0000", done); end
      req = 4'b0000;
      step();
      tests_run++;
      if (done !== 4'b0001) begin tests_failed++; $display("FAIL zero_done: got %b expected 0001", done); end
      tests_run++;
      if (grant !== 4'b0000) begin tests_failed++; $display("FAIL zero_grant_clr: got %b expected 0000", grant); end
      for (int k = 1; k <= 5; k++) begin
         tests_run++;
         if (led !== 1'b0) begin tests_failed++; $display("FAIL zero_led c%0d: got %b expected 0", k, led); end
         tests_run++;
         if (busy !== (k < 4)) begin tests_failed++; $display("FAIL zero_busy c%0d: got %b expected %b", k, busy, (k < 4)); end
         step();
      end
   endtask

   task automatic test_abort();
      logic exp_led;
      do_reset();
      blinks = 16'h0025;
      req    = 4'b0011;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp_led = (((k - 1) / 4) % 2) == 0;
         tests_run++;
         if (led !== exp_led) begin tests_failed++; $display("FAIL abort_led c%0d: got %b expected %b", k, led, exp_led); end
      end
      req = 4'b0010;
      step();
      tests_run++;
      if (led !== 1'b0) begin tests_failed++; $display("FAIL abort_led_drop: got %b expected 0", led); end
      tests_run++;
      if (grant !== 4'b0000) begin tests_failed++; $display("FAIL abort_grant_clr: got %b expected 0000", grant); end
      for (int k = 12; k <= 15; k++) begin
         tests_run++;
         if (done !== 4'b0000) begin tests_failed++; $display("FAIL abort_no_done c%0d: got %b expected 0000", k - 1, done); end
         step();
      end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_busy: got %b expected 0", busy); end
      step();
      tests_run++;
      if (grant !== 4'b0010) begin tests_failed++; $display("FAIL abort_next_grant: got %b expected 0010", grant); end
      tests_run++;
      if (led !== 1'b1) begin tests_failed++; $display("FAIL abort_next_led: got %b expected 1", led); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      blinks = 16'h0003;
      req    = 4'b0001;
      for (int k = 1; k <= 6; k++) step();
      tests_run++;
      if (led !== 1'b0 || grant !== 4'b0001) begin tests_failed++; $display("FAIL rstmid_pre: got led=%b grant=%b expected led=0 grant=0001", led, grant); end
      #2 rst_l = 1'b0;
      #1;
      tests_run++;
      if (grant !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_grant: got %b expected 0000", grant); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      tests_run++;
      if (done !== 4'b0000 || led !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done_led: got done=%b led=%b expected 0000 0", done, led); end
      step();
      req    = 4'b0110;
      blinks = 16'h0220;
      rst_l  = 1'b1;
      step();
      tests_run++;
      if (grant !== 4'b0010) begin tests_failed++; $display("FAIL rstmid_regrant: got %b expected 0010", grant); end
      tests_run++;
      if (done !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_no_done: got %b expected 0000", done); end
   endtask

   task automatic test_idle_led();
      logic exp_led;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         step();
`ifdef LED_BLINK_ARBITER_HEARTBEAT_EN
         exp_led = ((k / 4) % 2) == 1;
`else
         exp_led = 1'b0;
`endif
         tests_run++;
         if (led !== exp_led) begin tests_failed++; $display("FAIL idle_led c%0d: got %b expected %b", k, led, exp_led); end
         tests_run++;
         if (busy !== 1'b0 || grant !== 4'b0000) begin tests_failed++; $display("FAIL idle_quiet c%0d: got busy=%b grant=%b expected 0 0000", k, busy, grant); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_count();
      test_abort();
      test_reset_mid();
      test_idle_led();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
